// File: rtl/rst_seq_gen_if.sv
// -----------------------------------------------------------------------------
// rst_seq_gen_if
//   Groups the request/status signals of rst_seq_gen so the generator and its
//   consumer (or a testbench) connect through one bundle. The clock and the
//   asynchronous system reset stay plain ports on the module.
//
//   Signals
//     soft_rst_req_i  consumer -> generator  single-cycle soft reset request
//     rstn_o          generator -> consumer  staggered active-low resets
//     rst_done_o      generator -> consumer  all rstn_o bits released
//     stage_o         generator -> consumer  number of rstn_o bits released
//     dbg_state_o     generator -> consumer  current sequencer state encoding
//
//   Request semantics: there is no valid/ready pair. soft_rst_req_i is
//   sampled on every rising clk_sys_i edge and acts as a one-cycle "valid";
//   the generator is always "ready" in HOLD/STEP/DONE/SOFT, and drops the
//   request while still in SYNC because every output is already low there.
// -----------------------------------------------------------------------------
interface rst_seq_gen_if #(
    parameter int G_NUM_RST = 4
);
    logic                 soft_rst_req_i;
    logic [G_NUM_RST-1:0] rstn_o;
    logic                 rst_done_o;
    logic [4:0]           stage_o;
    logic [2:0]           dbg_state_o;

    // Consumer side: raises requests, observes the reset outputs.
    modport master (
        output soft_rst_req_i,
        input  rstn_o,
        input  rst_done_o,
        input  stage_o,
        input  dbg_state_o
    );

    // Generator side.
    modport slave (
        input  soft_rst_req_i,
        output rstn_o,
        output rst_done_o,
        output stage_o,
        output dbg_state_o
    );
endinterface

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//   Staggered reset sequencer. One system clock in, G_NUM_RST active-low reset
//   outputs released one after another so downstream pipeline stages come out
//   of reset in a fixed order. The release of sys_rstn_i is synchronised to
//   clk_sys_i, the first output follows after G_RST_DELAY cycles, each further
//   output after G_STAGE_GAP cycles. A soft request drops every output for
//   G_SOFT_RST_LEN cycles and then replays the full sequence.
//
//   Parameters
//     G_NUM_RST       number of reset outputs (1..16)
//     G_SYNC_STAGES   reset-release synchroniser depth (2..4)
//     G_RST_DELAY     cycles from synchronised release to rstn_o[0] high (>=1)
//     G_STAGE_GAP     cycles between consecutive output releases (>=1)
//     G_SOFT_RST_LEN  cycles all outputs are held low after a soft request (>=1)
//
//   Ports
//     clk_sys_i       in   system clock
//     sys_rstn_i      in   asynchronous active-low system reset
//     bus             rst_seq_gen_if.slave:
//                       soft_rst_req_i in, rstn_o / rst_done_o / stage_o /
//                       dbg_state_o out
//
//   Output properties: all outputs are registered, rstn_o is thermometer coded
//   (bit 0 released first), stage_o equals the number of released bits, and a
//   released bit only falls on sys_rstn_i or an accepted soft request.
// -----------------------------------------------------------------------------
module rst_seq_gen #(
    parameter int G_NUM_RST      = 4,
    parameter int G_SYNC_STAGES  = 2,
    parameter int G_RST_DELAY    = 16,
    parameter int G_STAGE_GAP    = 8,
    parameter int G_SOFT_RST_LEN = 4
) (
    input  logic         clk_sys_i,
    input  logic         sys_rstn_i,
    rst_seq_gen_if.slave bus
);

    function automatic int f_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // The counter only ever has to reach (longest interval - 1); one spare
    // value keeps the terminal compare from ever wrapping.
    localparam int C_CNT_MAX = f_max3(G_RST_DELAY, G_STAGE_GAP, G_SOFT_RST_LEN);
    localparam int CW        = $clog2(C_CNT_MAX + 1);

    // The FSM leaving SYNC acts as the last synchroniser flop, so only
    // G_SYNC_STAGES-1 dedicated flops are needed to make HOLD start on the
    // G_SYNC_STAGES-th rising edge after sys_rstn_i rises.
    localparam int SW = G_SYNC_STAGES - 1;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_HOLD = 3'd1,
        ST_STEP = 3'd2,
        ST_DONE = 3'd3,
        ST_SOFT = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [SW-1:0]        r_sync;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [G_NUM_RST-1:0] r_rstn;
    logic [4:0]           r_stage;
    logic                 r_done;

    // -------------------------------------------------------------------------
    // Next-state wires
    // -------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [G_NUM_RST-1:0] w_rstn_nxt;
    logic [4:0]           w_stage_nxt;
    logic                 w_done_nxt;

    logic                 w_sync_rel;
    logic [G_NUM_RST-1:0] w_rstn_shift;
    logic [4:0]           w_stage_inc;
    logic                 w_last;
    logic                 w_hold_end;
    logic                 w_step_end;
    logic                 w_soft_end;

    assign w_sync_rel = r_sync[SW-1];

    // Releasing the next output is a thermometer shift: one more 1 from bit 0.
    assign w_rstn_shift = (r_rstn << 1) | G_NUM_RST'(1);
    assign w_stage_inc  = r_stage + 5'd1;
    assign w_last       = (w_stage_inc == 5'(G_NUM_RST));

    assign w_hold_end = (r_cnt == CW'(G_RST_DELAY - 1));
    assign w_step_end = (r_cnt == CW'(G_STAGE_GAP - 1));
    assign w_soft_end = (r_cnt == CW'(G_SOFT_RST_LEN - 1));

    // -------------------------------------------------------------------------
    // Reset-release synchroniser: async clear, shifts in a constant 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= (r_sync << 1) | SW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_sys_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_state <= ST_SYNC;
            r_cnt   <= '0;
            r_rstn  <= '0;
            r_stage <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rstn  <= w_rstn_nxt;
            r_stage <= w_stage_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rstn_nxt  = r_rstn;
        w_stage_nxt = r_stage;
        w_done_nxt  = r_done;

        case (r_state)
            ST_SYNC: begin
                // Soft requests are dropped here: all outputs are low anyway.
                if (w_sync_rel) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            end

            ST_HOLD: begin
                if (bus.soft_rst_req_i) begin
                    w_state_nxt = ST_SOFT;
                    w_cnt_nxt   = '0;
                    w_rstn_nxt  = '0;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end else if (w_hold_end) begin
                    // With a single output this release is also the last one.
                    w_rstn_nxt  = w_rstn_shift;
                    w_stage_nxt = w_stage_inc;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = w_last;
                    w_state_nxt = w_last ? ST_DONE : ST_STEP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            ST_STEP: begin
                if (bus.soft_rst_req_i) begin
                    w_state_nxt = ST_SOFT;
                    w_cnt_nxt   = '0;
                    w_rstn_nxt  = '0;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end else if (w_step_end) begin
                    w_rstn_nxt  = w_rstn_shift;
                    w_stage_nxt = w_stage_inc;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = w_last;
                    w_state_nxt = w_last ? ST_DONE : ST_STEP;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            ST_DONE: begin
                if (bus.soft_rst_req_i) begin
                    w_state_nxt = ST_SOFT;
                    w_cnt_nxt   = '0;
                    w_rstn_nxt  = '0;
                    w_stage_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
            end

            ST_SOFT: begin
                // A fresh request restarts the hold-low window from zero.
                if (bus.soft_rst_req_i) begin
                    w_cnt_nxt = '0;
                end else if (w_soft_end) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = ST_SYNC;
                w_cnt_nxt   = '0;
                w_rstn_nxt  = '0;
                w_stage_nxt = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -------------------------------------------------------------------------
    assign bus.rstn_o      = r_rstn;
    assign bus.stage_o     = r_stage;
    assign bus.rst_done_o  = r_done;
    assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_gen
//   Directed bench for rst_seq_gen. dut0 uses the default parameters
//   (4 outputs, 2 sync stages, delay 16, gap 8, soft length 4); dut1 uses
//   1 output, 3 sync stages, delay 1, soft length 2. Inputs change on the
//   falling clock edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

    // Clock / reset
    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic rst1_n  = 1'b1;

    always #5 clk = ~clk;

    rst_seq_gen_if #(.G_NUM_RST(4)) bus0 ();
    rst_seq_gen_if #(.G_NUM_RST(1)) bus1 ();

    rst_seq_gen #(
        .G_NUM_RST      (4),
        .G_SYNC_STAGES  (2),
        .G_RST_DELAY    (16),
        .G_STAGE_GAP    (8),
        .G_SOFT_RST_LEN (4)
    ) dut0 (
        .clk_sys_i  (clk),
        .sys_rstn_i (rst_n),
        .bus        (bus0)
    );

    rst_seq_gen #(
        .G_NUM_RST      (1),
        .G_SYNC_STAGES  (3),
        .G_RST_DELAY    (1),
        .G_STAGE_GAP    (8),
        .G_SOFT_RST_LEN (2)
    ) dut1 (
        .clk_sys_i  (clk),
        .sys_rstn_i (rst1_n),
        .bus        (bus1)
    );

    // State encodings seen on dbg_state_o
    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_SOFT = 3'd4;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected {rstn_o, stage_o, rst_done_o} for dut0, k edges after HOLD
    // entry (k=0 is the entry edge; negative k means HOLD not reached yet).
    function automatic logic [9:0] exp_vec(input int k);
        int         s;
        logic [3:0] r;
        if (k < 16) begin
            s = 0;
        end else begin
            s = 1 + (k - 16) / 8;
            if (s > 4) s = 4;
        end
        r = 4'((1 << s) - 1);
        return {r, 5'(s), (s == 4)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Invariant monitor on dut0
    // -------------------------------------------------------------------------
    bit         mon_en       = 1'b0;
    bit         mon_rst_seen = 1'b0;
    logic [3:0] mon_prev     = 4'b0;

    always @(negedge rst_n) mon_rst_seen = 1'b1;

    always @(posedge clk) begin
        logic [3:0] cur;
        logic       thermo_ok, pop_ok, rst_ok, fall_ok;
        #1;
        if (mon_en) begin
            cur       = bus0.rstn_o;
            thermo_ok = ((cur & (cur + 4'd1)) === 4'b0);
            pop_ok    = (bus0.stage_o === 5'($countones(cur)));
            rst_ok    = !((rst_n === 1'b0) && (cur !== 4'b0));
            fall_ok   = ((mon_prev & ~cur) === 4'b0) || mon_rst_seen ||
                        (bus0.soft_rst_req_i === 1'b1);
            n_cmp++;
            if (!(thermo_ok && pop_ok && rst_ok && fall_ok)) begin
                n_bad++;
                $display("FAIL invariant t=%0t: rstn=%b stage=%0d prev=%b rst_n=%b req=%b (need thermometer, stage=popcount, low in reset, no unrequested fall)",
                         $time, cur, bus0.stage_o, mon_prev, rst_n, bus0.soft_rst_req_i);
            end
            mon_prev     = cur;
            mon_rst_seen = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        bus0.soft_rst_req_i = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_out0: got rstn=%b stage=%0d done=%b, want 0000/0/0",
                     bus0.rstn_o, bus0.stage_o, bus0.rst_done_o);
        end
        n_cmp++;
        if (bus0.dbg_state_o !== S_SYNC) begin
            n_bad++;
            $display("FAIL reset_state0: got %0d, want %0d", bus0.dbg_state_o, S_SYNC);
        end
        n_cmp++;
        if ({bus1.rstn_o, bus1.stage_o, bus1.rst_done_o} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_out1: got rstn=%b stage=%0d done=%b, want 0/0/0",
                     bus1.rstn_o, bus1.stage_o, bus1.rst_done_o);
        end
    endtask

    // Release sys_rstn_i with a soft request present during SYNC (ignored).
    task automatic test_power_up();
        logic [9:0] w;
        @(negedge clk);
        rst_n = 1'b1;
        bus0.soft_rst_req_i = 1'b1;
        for (int e = 1; e <= 46; e++) begin
            tick();
            if (e == 1) begin
                @(negedge clk);
                bus0.soft_rst_req_i = 1'b0;
                #1;
            end
            w = exp_vec(e - 2);  // E0 is the 2nd edge after release
            n_cmp++;
            if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL power_up e=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         e, bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, w[9:6], w[5:1], w[0]);
            end
        end
    endtask

    task automatic test_soft_done();
        logic [9:0] w;
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b1;
        tick();
        n_cmp++;
        if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, bus0.dbg_state_o} !== {10'b0, S_SOFT}) begin
            n_bad++;
            $display("FAIL soft_done_entry: got rstn=%b stage=%0d done=%b state=%0d, want 0000/0/0/%0d",
                     bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, bus0.dbg_state_o, S_SOFT);
        end
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b0;
        for (int j = 1; j <= 46; j++) begin
            tick();
            w = exp_vec(j - 4);
            n_cmp++;
            if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL soft_done j=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         j, bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, w[9:6], w[5:1], w[0]);
            end
            if (j == 4) begin
                n_cmp++;
                if (bus0.dbg_state_o !== S_HOLD) begin
                    n_bad++;
                    $display("FAIL soft_done_hold: got state %0d, want %0d", bus0.dbg_state_o, S_HOLD);
                end
            end
        end
    endtask

    // Request at rstn_o=0011, then again 2 cycles into SOFT.
    task automatic test_soft_mid_step();
        logic [9:0] w;
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b1;
        tick();
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b0;
        for (int j = 1; j <= 30; j++) tick();
        n_cmp++;
        if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== {4'b0011, 5'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_step_pre: got rstn=%b stage=%0d done=%b, want 0011/2/0",
                     bus0.rstn_o, bus0.stage_o, bus0.rst_done_o);
        end
        for (int j = 0; j <= 2; j++) begin
            @(negedge clk);
            bus0.soft_rst_req_i = (j != 1);
            tick();
            n_cmp++;
            if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, bus0.dbg_state_o} !== {10'b0, S_SOFT}) begin
                n_bad++;
                $display("FAIL mid_step_soft j=%0d: got rstn=%b stage=%0d done=%b state=%0d, want 0000/0/0/%0d",
                         j, bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, bus0.dbg_state_o, S_SOFT);
            end
        end
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b0;
        for (int j = 3; j <= 48; j++) begin
            tick();
            w = exp_vec(j - 6);
            n_cmp++;
            if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL mid_step_rerun j=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         j, bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, w[9:6], w[5:1], w[0]);
            end
        end
    endtask

    // Drop sys_rstn_i between edges at rstn_o=0111, then rerun power-up.
    task automatic test_async_reset();
        logic [9:0] w;
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b1;
        tick();
        @(negedge clk);
        bus0.soft_rst_req_i = 1'b0;
        for (int j = 1; j <= 38; j++) tick();   // k = 34
        n_cmp++;
        if (bus0.rstn_o !== 4'b0111) begin
            n_bad++;
            $display("FAIL async_pre: got rstn=%b, want 0111", bus0.rstn_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, bus0.dbg_state_o} !== {10'b0, S_SYNC}) begin
            n_bad++;
            $display("FAIL async_clear: got rstn=%b stage=%0d done=%b state=%0d, want 0000/0/0/%0d",
                     bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, bus0.dbg_state_o, S_SYNC);
        end
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 46; e++) begin
            tick();
            w = exp_vec(e - 2);
            n_cmp++;
            if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL async_rerun e=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         e, bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, w[9:6], w[5:1], w[0]);
            end
        end
    endtask

    // Sub-cycle low pulse on sys_rstn_i while in DONE.
    task automatic test_glitch();
        logic [9:0] w;
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== 10'b0) begin
            n_bad++;
            $display("FAIL glitch_clear: got rstn=%b stage=%0d done=%b, want 0000/0/0",
                     bus0.rstn_o, bus0.stage_o, bus0.rst_done_o);
        end
        for (int e = 1; e <= 46; e++) begin
            tick();
            w = exp_vec(e - 2);
            n_cmp++;
            if ({bus0.rstn_o, bus0.stage_o, bus0.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL glitch_rerun e=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         e, bus0.rstn_o, bus0.stage_o, bus0.rst_done_o, w[9:6], w[5:1], w[0]);
            end
        end
    endtask

    // dut1: 1 output, 3 sync stages, delay 1, soft length 2.
    task automatic test_small_cfg();
        logic [6:0] w;
        bus1.soft_rst_req_i = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            w = (e >= 4) ? {1'b1, 5'd1, 1'b1} : 7'b0;   // E0 = 3rd edge, release E0+1
            n_cmp++;
            if ({bus1.rstn_o, bus1.stage_o, bus1.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL small_power_up e=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         e, bus1.rstn_o, bus1.stage_o, bus1.rst_done_o, w[6], w[5:1], w[0]);
            end
        end
        n_cmp++;
        if (bus1.dbg_state_o !== S_DONE) begin
            n_bad++;
            $display("FAIL small_done_state: got %0d, want %0d", bus1.dbg_state_o, S_DONE);
        end
        @(negedge clk);
        bus1.soft_rst_req_i = 1'b1;
        tick();
        @(negedge clk);
        bus1.soft_rst_req_i = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            w = (j >= 3) ? {1'b1, 5'd1, 1'b1} : 7'b0;   // HOLD at S+2, release S+3
            n_cmp++;
            if ({bus1.rstn_o, bus1.stage_o, bus1.rst_done_o} !== w) begin
                n_bad++;
                $display("FAIL small_soft j=%0d: got rstn=%b stage=%0d done=%b, want %b/%0d/%b",
                         j, bus1.rstn_o, bus1.stage_o, bus1.rst_done_o, w[6], w[5:1], w[0]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        bus0.soft_rst_req_i = 1'b0;
        bus1.soft_rst_req_i = 1'b0;
        #1;
        rst_n  = 1'b0;
        rst1_n = 1'b0;
        mon_en = 1'b1;

        test_reset();
        test_power_up();
        test_soft_done();
        test_soft_mid_step();
        test_async_reset();
        test_glitch();
        test_small_cfg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
